// File: rtl/multi_digit_display_driver.sv
// rtl/multi_digit_display_driver.sv - multiplexed 7-segment driver with decimal/hex conversion
//
// Converts a captured binary value to BCD (iterative double-dabble) or hex
// nibbles, then scans the result across DIGITS multiplexed digits.
// Digit DIGITS-1 is the sign digit; digits 0..DIGITS-2 carry the value.
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - asynchronous active-low reset
//   load_i   - one-cycle strobe capturing value_i/hex_i/neg_i/blank_i (IDLE only)
//   value_i  - value to display
//   hex_i    - 1 = hex, 0 = decimal
//   neg_i    - 1 = value_i is two's complement
//   blank_i  - 1 = leading-zero blanking
//   busy_o   - conversion in progress
//   ovf_o    - last committed value did not fit
//   segment  - segment anodes, active high
//   digit    - digit cathodes, active low, at most one low

module multi_digit_display_driver #(
    parameter int DIGITS   = 4,
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 16,
    parameter int DEAD     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  value_i,
    input  logic              hex_i,
    input  logic              neg_i,
    input  logic              blank_i,
    output logic              busy_o,
    output logic              ovf_o,
    output logic [7:0]        segment,
    output logic [DIGITS-1:0] digit
);

    // Value digit count, and nibble count wide enough for both the BCD
    // result of a WIDTH-bit magnitude and the value digit positions.
    localparam int NV   = DIGITS - 1;
    localparam int NBCD = (WIDTH + 2) / 3;
    localparam int ND   = (NBCD > NV) ? NBCD : NV;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam int SW   = $clog2(SCAN_DIV);
    localparam int IW   = $clog2(DIGITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state;
    logic              sign_q;
    logic              hex_q;
    logic              blank_q;
    logic [WIDTH-1:0]  bin_q;
    logic [4*ND-1:0]   bcd_q;
    logic [CW-1:0]     cnt_q;
    logic [7:0]        disp_q [DIGITS];
    logic [SW-1:0]     slot_q;
    logic [IW-1:0]     idx_q;

    function automatic logic [7:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: seg_code = 8'h7e;
            4'h1: seg_code = 8'h30;
            4'h2: seg_code = 8'h6d;
            4'h3: seg_code = 8'h79;
            4'h4: seg_code = 8'h33;
            4'h5: seg_code = 8'h5b;
            4'h6: seg_code = 8'h5f;
            4'h7: seg_code = 8'h70;
            4'h8: seg_code = 8'h7f;
            4'h9: seg_code = 8'h7b;
            4'ha: seg_code = 8'h77;
            4'hb: seg_code = 8'h1f;
            4'hc: seg_code = 8'h4e;
            4'hd: seg_code = 8'h3d;
            4'he: seg_code = 8'h4f;
            default: seg_code = 8'h47;
        endcase
    endfunction

    // Capture-time sign and magnitude. Negating the most negative value
    // wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
    logic             in_neg;
    logic [WIDTH-1:0] in_mag;
    assign in_neg = neg_i && value_i[WIDTH-1];
    assign in_mag = in_neg ? (~value_i + WIDTH'(1)) : value_i;

    // One double-dabble step: adjust each nibble (>=5 -> +3), then shift the
    // whole {bcd, bin} pair left by one, carrying between nibbles.
    logic [4*ND-1:0] bcd_shift;
    logic [WIDTH-1:0] bin_shift;
    always_comb begin
        logic       carry;
        logic [3:0] nib;
        bcd_shift = '0;
        carry     = bin_q[WIDTH-1];
        for (int i = 0; i < ND; i++) begin
            nib = bcd_q[4*i +: 4];
            if (nib >= 4'd5)
                nib = nib + 4'd3;
            bcd_shift[4*i +: 4] = {nib[2:0], carry};
            carry = nib[3];
        end
        bin_shift = {bin_q[WIDTH-2:0], 1'b0};
    end

    // Result composition for COMMIT: pick BCD or hex nibbles, detect
    // overflow into non-displayable positions, and apply leading-zero blanking.
    logic [4*ND-1:0] src;
    logic            ovf_c;
    logic [NV-1:0]   show;
    logic [7:0]      new_code [DIGITS];
    always_comb begin
        logic seen;
        src = '0;
        src[WIDTH-1:0] = bin_q;
        if (!hex_q)
            src = bcd_q;

        ovf_c = 1'b0;
        for (int i = NV; i < ND; i++) begin
            if (src[4*i +: 4] != 4'd0)
                ovf_c = 1'b1;
        end

        // Walk from the top down; once the first nonzero digit (or digit 0)
        // is met, every lower digit is shown.
        seen = 1'b0;
        show = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (src[4*i +: 4] != 4'd0 || i == 0)
                seen = 1'b1;
            show[i] = seen || !blank_q;
        end

        for (int i = 0; i < DIGITS; i++)
            new_code[i] = 8'h00;
        for (int i = 0; i < NV; i++) begin
            if (ovf_c)
                new_code[i] = 8'h01;
            else if (show[i])
                new_code[i] = seg_code(src[4*i +: 4]);
            else
                new_code[i] = 8'h00;
        end
        new_code[NV] = sign_q ? 8'h01 : 8'h00;
    end

    // Control FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy_o  <= 1'b0;
            ovf_o   <= 1'b0;
            sign_q  <= 1'b0;
            hex_q   <= 1'b0;
            blank_q <= 1'b0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_i) begin
                        sign_q  <= in_neg;
                        hex_q   <= hex_i;
                        blank_q <= blank_i;
                        bin_q   <= in_mag;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_o  <= 1'b1;
                        state   <= hex_i ? COMMIT : CONV;
                    end
                end
                CONV: begin
                    bin_q <= bin_shift;
                    bcd_q <= bcd_shift;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1))
                        state <= COMMIT;
                end
                COMMIT: begin
                    ovf_o  <= ovf_c;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Scan position and display contents for the coming cycle. The output
    // registers are loaded from these so a commit shows up immediately.
    logic [SW-1:0] slot_n;
    logic [IW-1:0] idx_n;
    logic [7:0]    disp_n [DIGITS];
    always_comb begin
        if (slot_q == SW'(SCAN_DIV - 1)) begin
            slot_n = '0;
            idx_n  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            slot_n = slot_q + SW'(1);
            idx_n  = idx_q;
        end
        for (int i = 0; i < DIGITS; i++)
            disp_n[i] = (state == COMMIT) ? new_code[i] : disp_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            idx_q   <= '0;
            digit   <= '1;
            segment <= 8'h00;
            for (int i = 0; i < DIGITS; i++)
                disp_q[i] <= 8'h00;
        end else begin
            slot_q <= slot_n;
            idx_q  <= idx_n;
            for (int i = 0; i < DIGITS; i++)
                disp_q[i] <= disp_n[i];
            // Blank the first DEAD cycles of each slot to avoid ghosting.
            if (slot_n < SW'(DEAD)) begin
                digit   <= '1;
                segment <= 8'h00;
            end else begin
                digit   <= ~(DIGITS'(1) << idx_n);
                segment <= disp_n[idx_n];
            end
        end
    end

endmodule

// File: tb/tb_multi_digit_display_driver.sv
// tb/tb_multi_digit_display_driver.sv - self-checking bench for multi_digit_display_driver

module tb_multi_digit_display_driver;

    localparam int SD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load1 = 1'b0;
    logic       load2 = 1'b0;
    logic [7:0] val = 8'h00;
    logic       hex = 1'b0;
    logic       neg = 1'b0;
    logic       blank = 1'b0;
    logic       busy1, ovf1, busy2, ovf2;
    logic [7:0] seg1, seg2;
    logic [3:0] dig1;
    logic [1:0] dig2;

    always #5 clk = ~clk;

    multi_digit_display_driver #(.DIGITS(4), .WIDTH(8), .SCAN_DIV(SD), .DEAD(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .load_i(load1), .value_i(val), .hex_i(hex),
        .neg_i(neg), .blank_i(blank), .busy_o(busy1), .ovf_o(ovf1),
        .segment(seg1), .digit(dig1)
    );

    multi_digit_display_driver #(.DIGITS(2), .WIDTH(8), .SCAN_DIV(SD), .DEAD(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .load_i(load2), .value_i(val), .hex_i(hex),
        .neg_i(neg), .blank_i(blank), .busy_o(busy2), .ovf_o(ovf2),
        .segment(seg2), .digit(dig2)
    );

    int n_checks = 0;
    int n_fail = 0;
    int busy_cnt;
    logic [7:0] obs [4];
    bit bad_dead, bad_multi;
    logic [7:0] exp_seg [4];
    bit exp_ovf;
    logic [7:0] code_tab [16] = '{8'h7e, 8'h30, 8'h6d, 8'h79, 8'h33, 8'h5b, 8'h5f, 8'h70,
                                  8'h7f, 8'h7b, 8'h77, 8'h1f, 8'h4e, 8'h3d, 8'h4f, 8'h47};

    // Reference model: plain base-10/base-16 arithmetic on the magnitude.
    task automatic model(input logic [7:0] v, input bit hx, input bit ng, input bit bl, input int nd);
        int mag, base, lim, rem, msd;
        int dg [4];
        bit sgn;
        sgn  = ng && v[7];
        mag  = sgn ? 256 - int'(v) : int'(v);
        base = hx ? 16 : 10;
        lim  = 1;
        for (int p = 0; p < nd - 1; p++) lim = lim * base;
        exp_ovf = (mag >= lim);
        rem = mag;
        msd = 0;
        for (int p = 0; p < 4; p++) begin
            dg[p] = rem % base;
            rem   = rem / base;
            if (dg[p] != 0 && p < nd - 1) msd = p;
        end
        for (int p = 0; p < 4; p++) exp_seg[p] = 8'h00;
        for (int p = 0; p < nd - 1; p++) begin
            if (exp_ovf) exp_seg[p] = 8'h01;
            else if (!bl || p <= msd) exp_seg[p] = code_tab[dg[p]];
            else exp_seg[p] = 8'h00;
        end
        exp_seg[nd-1] = sgn ? 8'h01 : 8'h00;
    endtask

    // Drives one load strobe and counts busy cycles (bounded).
    task automatic do_load(input int sel, input logic [7:0] v, input bit hx, input bit ng, input bit bl);
        @(negedge clk);
        val = v; hex = hx; neg = ng; blank = bl;
        if (sel == 0) load1 = 1'b1; else load2 = 1'b1;
        @(negedge clk);
        load1 = 1'b0; load2 = 1'b0;
        busy_cnt = 0;
        while (((sel == 0) ? busy1 : busy2) && busy_cnt < 50) begin
            busy_cnt++;
            @(negedge clk);
        end
    endtask

    // Records the segment pattern seen for each enabled digit over two scan periods.
    task automatic observe(input int sel);
        logic [3:0] d;
        logic [7:0] s;
        int zeros, ix;
        for (int i = 0; i < 4; i++) obs[i] = 8'hee;
        bad_dead = 0; bad_multi = 0;
        for (int c = 0; c < 8 * SD; c++) begin
            @(negedge clk);
            d = (sel == 0) ? dig1 : {2'b11, dig2};
            s = (sel == 0) ? seg1 : seg2;
            if (d == 4'b1111) begin
                if (s != 8'h00) bad_dead = 1;
            end else begin
                zeros = 0; ix = 0;
                for (int i = 0; i < 4; i++) if (!d[i]) begin zeros++; ix = i; end
                if (zeros != 1) bad_multi = 1;
                else obs[ix] = s;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy1); end
        n_checks++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf1); end
        n_checks++; if (dig1 !== 4'b1111) begin n_fail++; $display("FAIL reset_digit got %b want 1111", dig1); end
        n_checks++; if (seg1 !== 8'h00) begin n_fail++; $display("FAIL reset_segment got %h want 00", seg1); end
        n_checks++; if (dig2 !== 2'b11) begin n_fail++; $display("FAIL reset_digit2 got %b want 11", dig2); end
    endtask

    task automatic test_scan;
        logic [3:0] want;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            want = (k % SD == 0) ? 4'b1111 : ~(4'b0001 << ((k / SD) % 4));
            n_checks++;
            if (dig1 !== want || seg1 !== 8'h00) begin
                n_fail++;
                $display("FAIL scan cycle %0d got digit=%b seg=%h want digit=%b seg=00", k, dig1, seg1, want);
            end
        end
    endtask

    task automatic test_decimal;
        logic [7:0] want [4] = '{8'h70, 8'h5b, 8'h30, 8'h00};
        do_load(0, 8'd157, 0, 0, 0);
        n_checks++; if (busy_cnt != 9) begin n_fail++; $display("FAIL dec_busy got %0d want 9", busy_cnt); end
        n_checks++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL dec_ovf got %b want 0", ovf1); end
        observe(0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs[i] !== want[i]) begin n_fail++; $display("FAIL dec157 digit%0d got %h want %h", i, obs[i], want[i]); end
        end
    endtask

    task automatic test_signed;
        logic [7:0] want_b [4] = '{8'h7e, 8'h30, 8'h00, 8'h01};
        logic [7:0] want_n [4] = '{8'h7e, 8'h30, 8'h7e, 8'h01};
        do_load(0, 8'hf6, 0, 1, 1);
        observe(0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs[i] !== want_b[i]) begin n_fail++; $display("FAIL neg10_blank digit%0d got %h want %h", i, obs[i], want_b[i]); end
        end
        do_load(0, 8'hf6, 0, 1, 0);
        observe(0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs[i] !== want_n[i]) begin n_fail++; $display("FAIL neg10_noblank digit%0d got %h want %h", i, obs[i], want_n[i]); end
        end
    endtask

    task automatic test_hex;
        logic [7:0] want [4] = '{8'h5b, 8'h77, 8'h00, 8'h00};
        do_load(0, 8'ha5, 1, 0, 1);
        n_checks++; if (busy_cnt != 1) begin n_fail++; $display("FAIL hex_busy got %0d want 1", busy_cnt); end
        observe(0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs[i] !== want[i]) begin n_fail++; $display("FAIL hexA5 digit%0d got %h want %h", i, obs[i], want[i]); end
        end
    endtask

    task automatic test_overflow;
        do_load(1, 8'd100, 0, 0, 0);
        observe(1);
        n_checks++; if (ovf2 !== 1'b1) begin n_fail++; $display("FAIL ovf100 flag got %b want 1", ovf2); end
        n_checks++; if (obs[0] !== 8'h01) begin n_fail++; $display("FAIL ovf100 digit0 got %h want 01", obs[0]); end
        do_load(1, 8'd9, 0, 0, 0);
        observe(1);
        n_checks++; if (ovf2 !== 1'b0) begin n_fail++; $display("FAIL ovf9 flag got %b want 0", ovf2); end
        n_checks++; if (obs[0] !== 8'h7b) begin n_fail++; $display("FAIL ovf9 digit0 got %h want 7b", obs[0]); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] want [4] = '{8'h70, 8'h5b, 8'h30, 8'h00};
        int cyc;
        do_load(0, 8'd0, 1, 0, 0);
        @(negedge clk);
        val = 8'd157; hex = 0; neg = 0; blank = 0; load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        repeat (2) @(negedge clk);
        val = 8'd42; hex = 1; neg = 1; blank = 1; load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        cyc = 0;
        while (busy1 && cyc < 50) begin cyc++; @(negedge clk); end
        n_checks++; if (cyc != 6) begin n_fail++; $display("FAIL b2b_busy_tail got %0d want 6", cyc); end
        observe(0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs[i] !== want[i]) begin n_fail++; $display("FAIL b2b digit%0d got %h want %h", i, obs[i], want[i]); end
        end
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL b2b_late_busy got %b want 0", busy1); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        val = 8'd200; hex = 0; neg = 0; blank = 0; load1 = 1'b1;
        @(negedge clk);
        load1 = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy1); end
        n_checks++; if (dig1 !== 4'b1111) begin n_fail++; $display("FAIL rstmid_digit got %b want 1111", dig1); end
        n_checks++; if (seg1 !== 8'h00) begin n_fail++; $display("FAIL rstmid_seg got %h want 00", seg1); end
        @(negedge clk);
        rst_n = 1'b1;
        observe(0);
        n_checks++; if (busy1 !== 1'b0 || ovf1 !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got busy=%b ovf=%b want 0 0", busy1, ovf1); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs[i] !== 8'h00) begin n_fail++; $display("FAIL rstmid_blank digit%0d got %h want 00", i, obs[i]); end
        end
    endtask

    task automatic test_random;
        logic [7:0] v;
        bit hx, ng, bl;
        int nd;
        for (int it = 0; it < 40; it++) begin
            int sel;
            sel = it % 2;
            nd  = (sel == 0) ? 4 : 2;
            v  = 8'($urandom_range(0, 255));
            hx = 1'($urandom_range(0, 1));
            ng = 1'($urandom_range(0, 1));
            bl = 1'($urandom_range(0, 1));
            if (it == 2) begin v = 8'h80; ng = 1; hx = 0; end
            if (it == 4) begin v = 8'h00; bl = 1; hx = 0; ng = 0; end
            do_load(sel, v, hx, ng, bl);
            model(v, hx, ng, bl, nd);
            n_checks++;
            if (busy_cnt != (hx ? 1 : 9)) begin n_fail++; $display("FAIL rnd%0d busy got %0d want %0d", it, busy_cnt, hx ? 1 : 9); end
            observe(sel);
            n_checks++;
            if (((sel == 0) ? ovf1 : ovf2) !== exp_ovf) begin n_fail++; $display("FAIL rnd%0d ovf v=%h got %b want %b", it, v, (sel == 0) ? ovf1 : ovf2, exp_ovf); end
            n_checks++;
            if (bad_dead || bad_multi) begin n_fail++; $display("FAIL rnd%0d scan dead=%b multi=%b want 0 0", it, bad_dead, bad_multi); end
            for (int i = 0; i < nd; i++) begin
                n_checks++;
                if (obs[i] !== exp_seg[i]) begin
                    n_fail++;
                    $display("FAIL rnd%0d v=%h hex=%b neg=%b blank=%b digit%0d got %h want %h", it, v, hx, ng, bl, i, obs[i], exp_seg[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_decimal;
        test_signed;
        test_hex;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
